// File: rtl/mdu_unit_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helpers for the
// iterative multiply/divide unit.
package mdu_unit_pkg;

    localparam logic [2:0] MDU_OP_NONE  = 3'd0;
    localparam logic [2:0] MDU_OP_MULT  = 3'd1;
    localparam logic [2:0] MDU_OP_MULTU = 3'd2;
    localparam logic [2:0] MDU_OP_DIV   = 3'd3;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        MDU_S_IDLE = 2'd0,
        MDU_S_MUL  = 2'd1,
        MDU_S_DIV  = 2'd2,
        MDU_S_FIX  = 2'd3
    } mdu_state_e;

    function automatic logic mdu_is_mul(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// EX-stage <-> MDU signal bundle; master is the pipeline side, slave the MDU.
interface mdu_unit_if #(parameter int DATA_W = 32);

    logic              start_i;
    logic [2:0]        mdu_op_i;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic              flush_i;
    logic              stall_o;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output start_i, mdu_op_i, a_i, b_i, flush_i,
        input  stall_o, busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, mdu_op_i, a_i, b_i, flush_i,
        output stall_o, busy_o, done_o, hi_o, lo_o
    );

endinterface

// File: rtl/mdu_unit_abs_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and
// result sign correction.
module mdu_abs_neg #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mdu_unit.sv
// Iterative MDU: shift-add multiply / restoring divide, one bit per cycle,
// owning the architectural HI/LO pair and stalling the front end while busy.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic      clk,
    input  logic      rst,
    mdu_unit_if.slave bus
);

    localparam int PW = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    mdu_state_e        r_state, w_state_nxt;
    logic [DATA_W-1:0] r_hi, r_lo;
    logic [DATA_W-1:0] r_acc_hi, r_acc_lo, r_b, r_a_raw;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sa, r_sb, r_is_div, r_dz, r_busy, r_done;

    logic              w_accept, w_step, w_fix_wr, w_sgn, w_last;
    logic [DATA_W-1:0] w_a_mag, w_b_mag;
    logic [DATA_W:0]   w_mul_sum, w_rem_sh;
    logic [DATA_W-1:0] w_diff;
    logic              w_ge;
    logic [PW-1:0]     w_prod;
    logic [DATA_W-1:0] w_quo, w_rem, w_hi_res, w_lo_res;

    assign w_sgn  = mdu_is_signed(bus.mdu_op_i);
    assign w_last = (r_cnt == LAST_CNT);

    mdu_abs_neg #(.W(DATA_W)) u_abs_a (
        .i_neg(w_sgn & bus.a_i[DATA_W-1]), .i_val(bus.a_i), .o_val(w_a_mag));
    mdu_abs_neg #(.W(DATA_W)) u_abs_b (
        .i_neg(w_sgn & bus.b_i[DATA_W-1]), .i_val(bus.b_i), .o_val(w_b_mag));
    mdu_abs_neg #(.W(PW)) u_fix_prod (
        .i_neg(r_sa ^ r_sb), .i_val({r_acc_hi, r_acc_lo}), .o_val(w_prod));
    mdu_abs_neg #(.W(DATA_W)) u_fix_quo (
        .i_neg(r_sa ^ r_sb), .i_val(r_acc_lo), .o_val(w_quo));
    mdu_abs_neg #(.W(DATA_W)) u_fix_rem (
        .i_neg(r_sa), .i_val(r_acc_hi), .o_val(w_rem));

    // Multiply: acc_hi collects partial sums, acc_lo shifts the multiplier out.
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    assign w_rem_sh = {r_acc_hi, r_acc_lo[DATA_W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_diff   = w_rem_sh[DATA_W-1:0] - r_b;

    assign w_hi_res = r_is_div ? (r_dz ? r_a_raw : w_rem) : w_prod[PW-1:DATA_W];
    assign w_lo_res = r_is_div ? (r_dz ? '1 : w_quo) : w_prod[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= MDU_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_fix_wr    = 1'b0;
        case (r_state)
            MDU_S_IDLE: begin
                // The done cycle still belongs to the finishing instruction.
                w_accept = bus.start_i & ~r_done & ~rst;
                if (w_accept && mdu_is_mul(bus.mdu_op_i))      w_state_nxt = MDU_S_MUL;
                else if (w_accept && mdu_is_div(bus.mdu_op_i)) w_state_nxt = MDU_S_DIV;
            end
            MDU_S_MUL, MDU_S_DIV: begin
                w_step = 1'b1;
                if (w_last) w_state_nxt = MDU_S_FIX;
            end
            MDU_S_FIX: begin
                w_fix_wr    = 1'b1;
                w_state_nxt = MDU_S_IDLE;
            end
            default: w_state_nxt = MDU_S_IDLE;
        endcase
        if (bus.flush_i) begin
            w_state_nxt = MDU_S_IDLE;
            w_accept    = 1'b0;
            w_step      = 1'b0;
            w_fix_wr    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_b      <= '0;
            r_a_raw  <= '0;
            r_cnt    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != MDU_S_IDLE);
            r_done <= w_fix_wr;
            if (w_accept) begin
                if (bus.mdu_op_i == MDU_OP_MTHI) r_hi <= bus.a_i;
                if (bus.mdu_op_i == MDU_OP_MTLO) r_lo <= bus.a_i;
                if (mdu_is_mul(bus.mdu_op_i) || mdu_is_div(bus.mdu_op_i)) begin
                    r_acc_hi <= '0;
                    r_acc_lo <= w_a_mag;
                    r_b      <= w_b_mag;
                    r_a_raw  <= bus.a_i;
                    r_sa     <= w_sgn & bus.a_i[DATA_W-1];
                    r_sb     <= w_sgn & bus.b_i[DATA_W-1];
                    r_is_div <= mdu_is_div(bus.mdu_op_i);
                    r_dz     <= (bus.b_i == '0);
                    r_cnt    <= '0;
                end
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_state == MDU_S_MUL) begin
                    {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[DATA_W-1:1]};
                end else begin
                    r_acc_hi <= w_ge ? w_diff : w_rem_sh[DATA_W-1:0];
                    r_acc_lo <= {r_acc_lo[DATA_W-2:0], w_ge};
                end
            end
            if (w_fix_wr) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
            end
        end
    end

    assign bus.stall_o = r_busy | (w_accept & (mdu_is_mul(bus.mdu_op_i) | mdu_is_div(bus.mdu_op_i)));
    assign bus.busy_o  = r_busy;
    assign bus.done_o  = r_done;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;

endmodule
